// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data port share one memory
// controller, with alternating tie-break and a wait-cycle timeout.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among eligible requesters
// GNT_IF | fetch owns the memory bus, waiting for mem_ack or timeout
// GNT_D  | data port owns the memory bus, waiting for mem_ack or timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       last_d;
    logic       if_cand, d_cand;
    logic       grant_if, grant_d, finish, timed_out;

    // A port whose valid is high this cycle is completing and must not re-arbitrate.
    assign if_cand = if_req & ~if_valid;
    assign d_cand  = d_req & ~d_valid;
    assign stall   = (if_req & ~if_valid) | (d_req & ~d_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (d_cand && (!if_cand || !last_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end else if (if_cand) begin
                    grant_if  = 1'b1;
                    state_nxt = GNT_IF;
                end
            end
            GNT_IF, GNT_D: begin
                if (mem_ack) begin
                    finish = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= 8'd0;
            last_d    <= 1'b0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            if_valid <= finish && (state == GNT_IF);
            d_valid  <= finish && (state == GNT_D);
            bus_err  <= timed_out;

            if (grant_if || grant_d)
                wait_cnt <= 8'd0;
            else if (state != IDLE && !mem_ack)
                wait_cnt <= wait_cnt + 8'd1;

            if (grant_d) begin
                last_d    <= 1'b1;
                mem_req   <= 1'b1;
                mem_wr    <= d_wr;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                last_d    <= 1'b0;
                mem_req   <= 1'b1;
                mem_wr    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
            end else if (finish) begin
                mem_req <= 1'b0;
                mem_wr  <= 1'b0;
            end

            // Writes and timeouts return zero read data.
            if (finish && state == GNT_IF)
                if_rdata <= timed_out ? 32'd0 : mem_rdata;
            if (finish && state == GNT_D)
                d_rdata <= (timed_out || mem_wr) ? 32'd0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// sequences for timeout, stall, reset mid-grant and tie alternation.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_wr, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, mem_req, mem_wr, bus_err, stall;

    int passed = 0;
    int total  = 0;

    mem_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_iv;
        logic [31:0] e_ird;
        logic        e_dv;
        logic [31:0] e_drd;
        logic        e_stall;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    initial begin
        int gnt;
        int n;
        int k;
        bit done;
        logic prev_req;
        logic order[4];

        // inputs: ir ia dr dw da dwd ack mrd | expected: mreq mwr maddr mwd iv ird dv drd stall
        vecs[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h0,    32'h0,        0, 32'h0,        0, 32'h0,        1};
        vecs[1]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0,        1};
        vecs[2]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,                     1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0,        1};
        vecs[3]  = '{1, 32'h100, 0, 0, 0, 0, 1, 32'hA5A5_0001,         1, 0, 32'h100,  32'h0,        0, 32'h0,        0, 32'h0,        1};
        vecs[4]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0,                     0, 0, 32'h100,  32'h0,        1, 32'hA5A5_0001, 0, 32'h0,       0};
        vecs[5]  = '{0, 32'h0,   0, 0, 0, 0, 0, 0,                     0, 0, 32'h100,  32'h0,        0, 32'hA5A5_0001, 0, 32'h0,       0};
        vecs[6]  = '{0, 32'h0, 1, 1, 32'h2000, 32'h1234_5678, 0, 0,    0, 0, 32'h100,  32'h0,        0, 32'hA5A5_0001, 0, 32'h0,       1};
        vecs[7]  = '{0, 32'h0, 1, 1, 32'h2000, 32'h1234_5678, 1, 32'hDEAD_BEEF,
                                                                       1, 1, 32'h2000, 32'h1234_5678, 0, 32'hA5A5_0001, 0, 32'h0,      1};
        vecs[8]  = '{0, 32'h0, 1, 1, 32'h2000, 32'h1234_5678, 0, 0,    0, 0, 32'h2000, 32'h1234_5678, 0, 32'hA5A5_0001, 1, 32'h0,      0};
        vecs[9]  = '{0, 32'h0, 0, 0, 0, 0, 1, 32'h7777_7777,           0, 0, 32'h2000, 32'h1234_5678, 0, 32'hA5A5_0001, 0, 32'h0,      0};
        vecs[10] = '{0, 32'h0, 1, 0, 32'h3000, 0, 0, 0,                0, 0, 32'h2000, 32'h1234_5678, 0, 32'hA5A5_0001, 0, 32'h0,      1};
        vecs[11] = '{0, 32'h0, 1, 0, 32'h3000, 0, 1, 32'h0BAD_F00D,    1, 0, 32'h3000, 32'h0,        0, 32'hA5A5_0001, 0, 32'h0,       1};
        vecs[12] = '{0, 32'h0, 1, 0, 32'h3000, 0, 0, 0,                0, 0, 32'h3000, 32'h0,        0, 32'hA5A5_0001, 1, 32'h0BAD_F00D, 0};
        vecs[13] = '{0, 32'h0, 0, 0, 0, 0, 0, 0,                       0, 0, 32'h3000, 32'h0,        0, 32'hA5A5_0001, 0, 32'h0BAD_F00D, 0};

        rst_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        #12;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: drive just after the rising edge, sample on the falling edge.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if_req = vecs[i].ir; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_wr = vecs[i].dw; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrd;
            @(negedge clk);
            check($sformatf("v%0d_mem_req", i),   32'(mem_req),  32'(vecs[i].e_mreq));
            check($sformatf("v%0d_mem_wr", i),    32'(mem_wr),   32'(vecs[i].e_mwr));
            check($sformatf("v%0d_mem_addr", i),  mem_addr,      vecs[i].e_maddr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata,     vecs[i].e_mwd);
            check($sformatf("v%0d_if_valid", i),  32'(if_valid), 32'(vecs[i].e_iv));
            check($sformatf("v%0d_if_rdata", i),  if_rdata,      vecs[i].e_ird);
            check($sformatf("v%0d_d_valid", i),   32'(d_valid),  32'(vecs[i].e_dv));
            check($sformatf("v%0d_d_rdata", i),   d_rdata,       vecs[i].e_drd);
            check($sformatf("v%0d_bus_err", i),   32'(bus_err),  32'd0);
            check($sformatf("v%0d_stall", i),     32'(stall),    32'(vecs[i].e_stall));
        end

        // Timeout: data read never acknowledged.
        @(posedge clk); #1;
        d_req = 1; d_wr = 0; d_addr = 32'h50; mem_ack = 0;
        gnt = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mem_req) gnt++;
            if (d_valid) begin
                done = 1;
                check("to_gnt_cycles", 32'(gnt), 32'd64);
                check("to_bus_err", 32'(bus_err), 32'd1);
                check("to_d_rdata", d_rdata, 32'd0);
                check("to_if_valid", 32'(if_valid), 32'd0);
            end
        end
        if (!done) check("to_wait_expired", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 0;
        @(negedge clk);
        check("to_bus_err_pulse", 32'(bus_err), 32'd0);
        check("to_d_valid_pulse", 32'(d_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1; mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        @(posedge clk); #1; mem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_ack_d_valid", 32'(d_valid), 32'd0);
            check("late_ack_bus_err", 32'(bus_err), 32'd0);
            check("late_ack_mem_req", 32'(mem_req), 32'd0);
        end

        // Stall across a 4-cycle fetch.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h140; mem_rdata = 32'h5A5A_0002;
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_req) n++;
            mem_ack = (mem_req && n == 4);
            if (if_valid) begin
                done = 1;
                check("stall_valid_cycle", 32'(stall), 32'd0);
                check("stall_if_rdata", if_rdata, 32'h5A5A_0002);
            end else begin
                check("stall_pending", 32'(stall), 32'd1);
            end
        end
        if (!done) check("stall_wait_expired", 32'd0, 32'd1);
        check("stall_gnt_cycles", 32'(n), 32'd4);
        @(posedge clk); #1;
        if_req = 0; mem_ack = 0;
        @(negedge clk);
        check("stall_after", 32'(stall), 32'd0);

        // Reset asserted in the second GNT_IF cycle.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h180;
        @(posedge clk); #1;
        @(negedge clk);
        check("rmg_granted", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("rmg_mem_req", 32'(mem_req), 32'd0);
        check("rmg_mem_addr", mem_addr, 32'd0);
        check("rmg_if_rdata", if_rdata, 32'd0);
        check("rmg_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        if_req = 0; rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            mem_ack = (i == 1);
            @(negedge clk);
            check("rmg_no_if_valid", 32'(if_valid), 32'd0);
            check("rmg_no_mem_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 0;

        // Tie after reset: both held, grants alternate starting with data.
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h400; d_req = 1; d_wr = 0; d_addr = 32'h800;
        k = 0; prev_req = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if (if_valid) check("tie_if_rdata", if_rdata, 32'h401);
            if (d_valid)  check("tie_d_rdata", d_rdata, 32'h801);
            if (mem_req && !prev_req) begin
                order[k] = (mem_addr == 32'h800);
                k++;
            end
            prev_req  = mem_req;
            mem_ack   = mem_req;
            mem_rdata = mem_addr + 32'd1;
        end
        if (k < 4) check("tie_wait_expired", 32'(k), 32'd4);
        else begin
            check("tie_grant0_d",  32'(order[0]), 32'd1);
            check("tie_grant1_if", 32'(order[1]), 32'd0);
            check("tie_grant2_d",  32'(order[2]), 32'd1);
            check("tie_grant3_if", 32'(order[3]), 32'd0);
        end
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        repeat (4) @(posedge clk);
        mem_ack = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
